// File: rtl/note_display_sequencer.sv
//==============================================================================
// Module      : note_display_sequencer
// Description : Decodes PS/2 scan codes into a note FIFO and presents one note
//               at a time to the VGA renderer, updating only on frame_start.
//               Optional macro NOTE_SEQ_REPEAT_FILTER_EN suppresses typematic
//               repeats of the currently held note key.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module note_display_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                          clk_100MHz,
    input  logic                          reset,
    input  logic [7:0]                    rx_byte,
    input  logic                          rx_valid,
    input  logic                          frame_start,
    output logic [7:0]                    scan,
    output logic [7:0]                    prevscan,
    output logic                          note_active,
    output logic [$clog2(FIFO_DEPTH):0]   queue_count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [7:0]       PFX_BREAK  = 8'hF0;
    localparam logic [7:0]       PFX_EXT    = 8'hE0;
    localparam logic [7:0]       KEY_SHIFT  = 8'h12;
    localparam logic [7:0]       KEY_ESC    = 8'h76;
    localparam logic [7:0]       SCAN_BLANK = 8'h76;
    localparam logic [7:0]       OCT_UPPER  = 8'h12;
    localparam logic [7:0]       OCT_LOWER  = 8'h00;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       HOLD_C     = 8'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_t;

    dec_state_t       dec_state;
    dec_state_t       dec_next;

    logic             shift_flag;
    logic             is_note;
    logic             make_note;
    logic             flush;
    logic             set_shift;
    logic             clr_shift;
    logic             push_req;

    logic [8:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic [8:0]       head;

    logic [7:0]       hold_cnt;
    logic             hold_done;
    logic             blank_pending;

    always_comb begin
        is_note = 1'b0;
        case (rx_byte)
            8'h23, 8'h2D, 8'h3A, 8'h2B, 8'h1B, 8'h4B, 8'h21: is_note = 1'b1;
            default:                                         is_note = 1'b0;
        endcase
    end

    // Decoder: state register
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            dec_state <= IDLE;
        end else begin
            dec_state <= dec_next;
        end
    end

    // Decoder: next state and per-byte actions
    always_comb begin
        dec_next  = dec_state;
        make_note = 1'b0;
        flush     = 1'b0;
        set_shift = 1'b0;
        clr_shift = 1'b0;
        if (rx_valid) begin
            case (dec_state)
                IDLE: begin
                    if (rx_byte == PFX_BREAK) begin
                        dec_next = BRK;
                    end else if (rx_byte == PFX_EXT) begin
                        dec_next = EXT;
                    end else if (rx_byte == KEY_SHIFT) begin
                        set_shift = 1'b1;
                    end else if (rx_byte == KEY_ESC) begin
                        flush = 1'b1;
                    end else if (is_note) begin
                        make_note = 1'b1;
                    end
                end
                BRK: begin
                    dec_next  = IDLE;
                    clr_shift = (rx_byte == KEY_SHIFT);
                end
                EXT: begin
                    dec_next = (rx_byte == PFX_BREAK) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    dec_next = IDLE;
                end
                default: begin
                    dec_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            shift_flag <= 1'b0;
        end else if (set_shift) begin
            shift_flag <= 1'b1;
        end else if (clr_shift) begin
            shift_flag <= 1'b0;
        end
    end

`ifdef NOTE_SEQ_REPEAT_FILTER_EN
    logic [7:0] held_key;
    logic       held_valid;
    logic       repeat_hit;
    logic       held_release;

    assign repeat_hit   = held_valid && (held_key == rx_byte);
    assign held_release = rx_valid && (dec_state == BRK) && repeat_hit;

    // The held key tracks the latest note make even if its push is dropped.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            held_key   <= 8'h00;
            held_valid <= 1'b0;
        end else if (flush || held_release) begin
            held_valid <= 1'b0;
        end else if (make_note) begin
            held_key   <= rx_byte;
            held_valid <= 1'b1;
        end
    end

    assign push_req = make_note && !repeat_hit;
`else
    assign push_req = make_note;
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);
    assign hold_done  = (hold_cnt <= 8'd1);
    assign head       = mem[rd_ptr];

    // Pop decisions use the pre-push occupancy; a flush suppresses the pop.
    assign pop     = frame_start && !blank_pending && !flush && hold_done && !fifo_empty;
    assign push_ok = push_req && (!fifo_full || pop);
    assign drop    = push_req && fifo_full && !pop;

    always_ff @(posedge clk_100MHz) begin
        if (push_ok) begin
            mem[wr_ptr] <= {shift_flag, rx_byte};
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign queue_count = count;

    // Frame scheduler: outputs move only on frame_start.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            scan          <= SCAN_BLANK;
            prevscan      <= OCT_LOWER;
            note_active   <= 1'b0;
            hold_cnt      <= 8'd0;
            blank_pending <= 1'b0;
        end else if (frame_start) begin
            if (blank_pending || flush) begin
                scan          <= SCAN_BLANK;
                prevscan      <= OCT_LOWER;
                note_active   <= 1'b0;
                blank_pending <= 1'b0;
                if (flush) begin
                    hold_cnt <= 8'd0;
                end
            end else if (!hold_done) begin
                hold_cnt <= hold_cnt - 8'd1;
            end else if (!fifo_empty) begin
                scan        <= head[7:0];
                prevscan    <= head[8] ? OCT_UPPER : OCT_LOWER;
                note_active <= 1'b1;
                hold_cnt    <= HOLD_C;
            end else begin
                hold_cnt <= 8'd0;
                if (note_active) begin
                    scan        <= SCAN_BLANK;
                    prevscan    <= OCT_LOWER;
                    note_active <= 1'b0;
                end
            end
        end else if (flush) begin
            hold_cnt      <= 8'd0;
            blank_pending <= 1'b1;
        end
    end

endmodule

`default_nettype wire
